button_conditioner: RTL and testbench
=====================================

# button_conditioner

Parametrised multi-channel push-button conditioner for the calculator front end. Each of `N` raw button inputs passes through a multi-stage synchroniser and an independent per-channel debounce counter. Each channel produces a stable level plus single-cycle press and release strobes, so the keypad decoder and calculator FSM no longer need their own edge detectors. Optional auto-repeat generates periodic press strobes while a key is held.

## Interface
- `N`, 4: number of button channels.
- `CNT_W`, 17: debounce counter width; stability window is 2^CNT_W cycles.
- `SYNC_STAGES`, 2: synchroniser flip-flop stages, minimum 2.
- `ACTIVE_LOW`, 0: when 1, `PB` is inverted after synchronisation, so internal "pressed" = 1.
- `REP_DELAY`, 50_000_000: cycles from debounced press to first repeat strobe (used only with `REPEAT_EN`).
- `REP_PERIOD`, 10_000_000: cycles between subsequent repeat strobes (used only with `REPEAT_EN`).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `PB`  in  N  raw asynchronous button inputs.
- `BUTTONS`  out  N  debounced level, 1 = pressed.
- `PRESSED`  out  N  one-cycle strobe on debounced 0→1, and on each auto-repeat.
- `RELEASED`  out  N  one-cycle strobe on debounced 1→0.

## Operation
- Reset (async assert, sync release handled upstream): all synchroniser flops, `BUTTONS`, counters, `PRESSED` and `RELEASED` are set to 0. Repeat state is cleared.
- Per channel `i`, `s` = last synchroniser stage XOR `ACTIVE_LOW`.
- Debounce, per channel:
  - If `s == BUTTONS[i]`: `cnt` ← 0.
  - Else if `cnt` is all-ones: `BUTTONS[i]` ← `s` and `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1, wrapping never occurs.
- Any single cycle of agreement between `s` and `BUTTONS[i]` restarts the window.
- `PRESSED[i]`/`RELEASED[i]` are registered and high for exactly the cycle in which `BUTTONS[i]` first shows its new value.
- `PRESSED` and `RELEASED` are never high together on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Reset asserted mid-window discards partial count. After release, a held button is re-detected as a fresh press (full window).

## Timing
- Latency from a stable `PB` edge to `BUTTONS`/strobe: `SYNC_STAGES` + 2^CNT_W cycles.
- Minimum rejected glitch: any pulse shorter than 2^CNT_W cycles, as seen at the synchroniser output, is suppressed entirely.
- All outputs are registered; there are no combinational paths from `PB`.

## Configuration
- `BUTTON_CONDITIONER_REPEAT_EN` defined:
  - Each channel has a repeat counter wide enough for max(`REP_DELAY`, `REP_PERIOD`), cleared on the debounced press.
  - While `BUTTONS[i]`=1, an extra `PRESSED[i]` strobe fires `REP_DELAY` cycles after the press strobe, then every `REP_PERIOD` cycles.
  - Release or reset stops repeat immediately. No repeat strobe fires in the `RELEASED` cycle.
- Not defined: no repeat logic is synthesised. `PRESSED` fires once per debounced press. `REP_DELAY`/`REP_PERIOD` are ignored.

## Test plan
All scenarios use `N`=4, `CNT_W`=3, `SYNC_STAGES`=2, `ACTIVE_LOW`=0.
- Reset release with `PB`=4'b0000 held → `BUTTONS`, `PRESSED`, `RELEASED` stay 0 for 50 cycles.
- `PB[0]` 0→1 at cycle 0 and held → `BUTTONS[0]`=1 and `PRESSED[0]`=1 at cycle 10 only; `PRESSED[0]`=0 at cycle 11.
- `PB[1]` high for 5 cycles then low → no change on any output.
- `PB[2]` bounces (1,0,1,0,1 each 2 cycles) then holds 1 → a single `PRESSED[2]` 10 cycles after the last bounce; then `PB[2]`→0 gives `RELEASED[2]` 10 cycles later.
- `PB`=4'b1111 at the same cycle → all four `PRESSED` bits high in the same cycle. Assert `rst_n` mid-window on another run → outputs 0 at once, and full latency is required after release.
- With `BUTTON_CONDITIONER_REPEAT_EN`, `REP_DELAY`=20, `REP_PERIOD`=5: hold `PB[3]` → `PRESSED[3]` strobes at press time T, then T+20, T+25, T+30. Release → `RELEASED[3]` strobes, with no further `PRESSED[3]`.

Source files
------------

// File: rtl/button_conditioner.sv
// N-channel push-button synchroniser + debouncer giving level, press and release strobes; latency SYNC_STAGES+2^CNT_W cycles, no backpressure (free-running).
// Define BUTTON_CONDITIONER_REPEAT_EN to add per-channel auto-repeat PRESSED strobes while a key is held.
module button_conditioner #(
    parameter int N           = 4,
    parameter int CNT_W       = 17,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0,
    parameter int REP_DELAY   = 50_000_000,
    parameter int REP_PERIOD  = 10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] PB,
    output logic [N-1:0] BUTTONS,
    output logic [N-1:0] PRESSED,
    output logic [N-1:0] RELEASED
);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     pol;
    logic [N-1:0]     s;

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     btn_q, btn_d;
    logic [N-1:0]     press_q, press_d;
    logic [N-1:0]     rel_q, rel_d;
    logic [N-1:0]     press_next;

    assign pol = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    assign s   = sync_q[SYNC_STAGES-1] ^ pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= PB;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Any cycle of agreement restarts the window; the level flips only after a full saturated count.
    always_comb begin
        btn_d   = btn_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == btn_q[i]) begin
                cnt_d[i] = '0;
            end else if (&cnt_q[i]) begin
                cnt_d[i]   = '0;
                btn_d[i]   = s[i];
                press_d[i] = s[i];
                rel_d[i]   = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q [N];
    logic [REP_W-1:0] rep_cnt_d [N];
    logic [N-1:0]     rep_per_q, rep_per_d;
    logic [N-1:0]     rep_fire;

    // Counting only runs while the key stays held across this edge, so no repeat lands on a release cycle.
    always_comb begin
        rep_per_d = '0;
        rep_fire  = '0;
        for (int i = 0; i < N; i++) begin
            rep_cnt_d[i] = '0;
            if (btn_q[i] && btn_d[i]) begin
                if (rep_cnt_q[i] == (rep_per_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    rep_fire[i]  = 1'b1;
                    rep_per_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                    rep_per_d[i] = rep_per_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_per_q <= '0;
            for (int i = 0; i < N; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            rep_per_q <= rep_per_d;
            for (int i = 0; i < N; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign press_next = press_d | rep_fire;
`else
    assign press_next = press_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_q   <= btn_d;
            press_q <= press_next;
            rel_q   <= rel_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign BUTTONS  = btn_q;
    assign PRESSED  = press_q;
    assign RELEASED = rel_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing inputs against a sliding-window reference model.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int W  = 8;   // 2^CNT_W with CNT_W = 3
    localparam int RD = 20;
    localparam int RP = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] PB;
    logic [N-1:0] BUTTONS;
    logic [N-1:0] PRESSED;
    logic [N-1:0] RELEASED;

    int checks = 0;
    int errors = 0;

    // Reference state: level per channel, strobes, PB history (ph[0] = newest sample), age since press
    logic [N-1:0] m_btn, m_pr, m_rl;
    logic [N-1:0] ph [10];
    int           age [N];

    button_conditioner #(
        .N(N), .CNT_W(3), .SYNC_STAGES(2), .ACTIVE_LOW(0),
        .REP_DELAY(RD), .REP_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PB(PB),
        .BUTTONS(BUTTONS), .PRESSED(PRESSED), .RELEASED(RELEASED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_btn = '0;
        m_pr  = '0;
        m_rl  = '0;
        for (int k = 0; k < 10; k++) ph[k] = '0;
        for (int c = 0; c < N; c++) age[c] = -1;
    endtask

    // A level flips at an edge when the W synchronised samples ending at that edge all disagree with it.
    task automatic model_edge(input logic [N-1:0] pb);
        logic [N-1:0] nb;
        logic         all_diff;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < W; j++) begin
                if (ph[1+j][c] == m_btn[c]) all_diff = 1'b0;
            end
            nb[c] = all_diff ? ~m_btn[c] : m_btn[c];
        end
        m_pr = nb & ~m_btn;
        m_rl = m_btn & ~nb;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        for (int c = 0; c < N; c++) begin
            if (m_pr[c]) begin
                age[c] = 0;
            end else if (nb[c]) begin
                age[c]++;
                if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)) m_pr[c] = 1'b1;
            end else begin
                age[c] = -1;
            end
        end
`endif
        m_btn = nb;
        for (int k = 9; k > 0; k--) ph[k] = ph[k-1];
        ph[0] = pb;
    endtask

    task automatic tick(input logic [N-1:0] pb);
        PB = pb;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(pb);
        #1;
        chk("buttons", BUTTONS, m_btn);
        chk("pressed", PRESSED, m_pr);
        chk("released", RELEASED, m_rl);
        chk("exclusive", PRESSED & RELEASED, '0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_buttons", BUTTONS, '0);
        chk("rst_pressed", PRESSED, '0);
        chk("rst_released", RELEASED, '0);
    endtask

    initial begin
        logic [N-1:0] rpb;
        int           hold [N];
        logic         bnc;

        rst_n = 1'b0;
        PB    = '0;
        model_reset();
        for (int k = 0; k < 3; k++) tick(4'b0000);
        rst_n = 1'b1;

        // Idle after reset
        for (int k = 1; k <= 50; k++) begin
            tick(4'b0000);
            chk("idle_buttons", BUTTONS, 4'b0000);
            chk("idle_strobes", PRESSED | RELEASED, 4'b0000);
        end

        // Single press, then release
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0001);
            chk("press0", {3'b000, PRESSED[0]}, {3'b000, k == 10});
            chk("level0", {3'b000, BUTTONS[0]}, {3'b000, k >= 10});
        end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000);
            chk("release0", {3'b000, RELEASED[0]}, {3'b000, k == 10});
        end

        // Short pulse is rejected
        for (int k = 1; k <= 20; k++) begin
            tick((k <= 5) ? 4'b0010 : 4'b0000);
            chk("glitch_level", BUTTONS, 4'b0000);
            chk("glitch_strobes", PRESSED | RELEASED, 4'b0000);
        end

        // Bouncing press: only the final stable level counts
        for (int k = 1; k <= 25; k++) begin
            bnc = (k <= 2) || (k >= 5 && k <= 6) || (k >= 9);
            tick({1'b0, bnc, 2'b00});
            chk("bounce_press", {3'b000, PRESSED[2]}, {3'b000, k == 18});
        end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000);
            chk("bounce_release", {3'b000, RELEASED[2]}, {3'b000, k == 10});
        end

        // Simultaneous press and release on all channels
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1111);
            chk("all_press", PRESSED, (k == 10) ? 4'b1111 : 4'b0000);
        end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000);
            chk("all_release", RELEASED, (k == 10) ? 4'b1111 : 4'b0000);
        end

        // Reset mid-window with one key already down, then full latency after release
        for (int k = 1; k <= 12; k++) tick(4'b1000);
        for (int k = 1; k <= 4; k++) tick(4'b1111);
        async_reset();
        tick(4'b1111);
        tick(4'b1111);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1111);
            chk("post_rst_press", PRESSED, (k == 10) ? 4'b1111 : 4'b0000);
        end
        for (int k = 1; k <= 12; k++) tick(4'b0000);

`ifdef BUTTON_CONDITIONER_REPEAT_EN
        // Auto-repeat while held; release edge coincides with a repeat slot
        for (int k = 1; k <= 45; k++) begin
            tick(4'b1000);
            if (k <= 41)
                chk("repeat", {PRESSED[3], 3'b000},
                    {(k == 10 || k == 30 || k == 35 || k == 40), 3'b000});
        end
        for (int k = 1; k <= 14; k++) begin
            tick(4'b0000);
            chk("repeat_release", {RELEASED[3], 3'b000}, {k == 10, 3'b000});
            if (k >= 10) chk("repeat_stop", {PRESSED[3], 3'b000}, 4'b0000);
        end
`endif

        // Random bouncing keys with occasional resets
        rpb = '0;
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 14);
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    rpb[c]  = ~rpb[c];
                    hold[c] = $urandom_range(1, 14);
                end
                hold[c]--;
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
                tick(rpb);
                rst_n = 1'b1;
            end
            tick(rpb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
